// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - multi-lane early branch/JAL redirect and U-type CDB result queue
// Optional macro BRU_STATS_EN adds saturating misdirectCount / killedLaneCount outputs.
module branch_redirect_unit #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 2,
  parameter int TAGW   = 5,
  parameter int QDEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [LANES-1:0]       laneValid,
  input  logic [LANES-1:0]       isBranch,
  input  logic [LANES-1:0]       isJAL,
  input  logic [LANES-1:0]       isLUI,
  input  logic [LANES-1:0]       isAUIPC,
  input  logic [LANES*WIDTH-1:0] PC,
  input  logic [LANES*WIDTH-1:0] immExt,
  input  logic [LANES*WIDTH-1:0] predictedPC,
  input  logic [LANES*TAGW-1:0]  robTag,
  input  logic                   commitFlush,
  input  logic                   fetchReady,
  input  logic                   cdbGrant,
  output logic                   stall,
  output logic                   redirectValid,
  output logic [WIDTH-1:0]       redirectPC,
  output logic [TAGW-1:0]        redirectTag,
  output logic [LANES-1:0]       laneKill,
  output logic                   cdbReq,
  output logic [WIDTH-1:0]       cdbData,
  output logic [TAGW-1:0]        cdbTag
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]            misdirectCount,
  output logic [15:0]            killedLaneCount
`endif
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_data [QDEPTH];
  logic [TAGW-1:0]  q_tag  [QDEPTH];

  logic             accept;
  logic             any_mis;
  logic             deq;
  logic [WIDTH-1:0] sel_pc;
  logic [TAGW-1:0]  sel_tag;
  logic [LANES-1:0] kill_mask;
  logic [LANES-1:0] enq_en;
  logic [PW-1:0]    enq_off  [LANES];
  logic [WIDTH-1:0] u_result [LANES];
  logic [CW-1:0]    n_enq;

  // Stall looks only at registered state so rename never sees a lane-to-stall path.
  assign cdbReq  = (count != '0);
  assign stall   = redirectValid | (int'(count) > QDEPTH - LANES);
  assign accept  = ~stall & ~commitFlush;
  assign deq     = cdbReq & cdbGrant & ~commitFlush;
  assign cdbData = cdbReq ? q_data[rd_ptr] : '0;
  assign cdbTag  = cdbReq ? q_tag[rd_ptr]  : '0;

  // One pass oldest-to-youngest: the first misdirect marks every later lane killed
  // and blocks U-type enqueue from itself onward.
  always_comb begin
    logic             seen;
    logic [WIDTH-1:0] tgt;
    int               n;
    seen      = 1'b0;
    tgt       = '0;
    n         = 0;
    sel_pc    = '0;
    sel_tag   = '0;
    kill_mask = '0;
    enq_en    = '0;
    for (int i = 0; i < LANES; i++) begin
      tgt          = PC[i*WIDTH +: WIDTH] + immExt[i*WIDTH +: WIDTH];
      u_result[i]  = isLUI[i] ? immExt[i*WIDTH +: WIDTH] : tgt;
      kill_mask[i] = seen;
      if (!seen && laneValid[i] && (isBranch[i] || isJAL[i]) &&
          (tgt != predictedPC[i*WIDTH +: WIDTH])) begin
        sel_pc  = tgt;
        sel_tag = robTag[i*TAGW +: TAGW];
        seen    = 1'b1;
      end
      enq_en[i]  = accept & ~seen & laneValid[i] & (isLUI[i] | isAUIPC[i]);
      enq_off[i] = PW'(n);
      if (enq_en[i]) n++;
    end
    any_mis = seen;
    n_enq   = CW'(n);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirectValid <= 1'b0;
      redirectPC    <= '0;
      redirectTag   <= '0;
      laneKill      <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
    end else if (commitFlush) begin
      redirectValid <= 1'b0;
      laneKill      <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
    end else begin
      if (accept && any_mis) begin
        redirectValid <= 1'b1;
        redirectPC    <= sel_pc;
        redirectTag   <= sel_tag;
        laneKill      <= kill_mask;
      end else if (redirectValid && fetchReady) begin
        redirectValid <= 1'b0;
        laneKill      <= '0;
      end
      rd_ptr <= rd_ptr + PW'(deq);
      wr_ptr <= wr_ptr + PW'(n_enq);
      count  <= count + n_enq - CW'(deq);
    end
  end

  // Payload storage needs no reset: cdbData/cdbTag are gated by cdbReq.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (enq_en[i]) begin
        q_data[wr_ptr + enq_off[i]] <= u_result[i];
        q_tag[wr_ptr + enq_off[i]]  <= robTag[i*TAGW +: TAGW];
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [15:0] kill_pop;
  logic [16:0] kill_sum;

  always_comb begin
    kill_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      kill_pop = kill_pop + 16'(kill_mask[i] & laneValid[i]);
    end
    kill_sum = {1'b0, killedLaneCount} + {1'b0, kill_pop};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      misdirectCount  <= '0;
      killedLaneCount <= '0;
    end else if (accept && any_mis) begin
      if (misdirectCount != 16'hFFFF) misdirectCount <= misdirectCount + 16'd1;
      killedLaneCount <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
  end
`endif

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Multi-lane early branch/jump target resolver for the instruction rename stage. Each cycle it takes up to LANES decoded instructions, oldest in lane 0. For every conditional branch and JAL it computes PC+immExt and compares the result against the fetch-predicted PC. It registers a single redirect for the oldest misdirected lane and holds it until fetch accepts. U-type instructions (LUI/AUIPC) are executed here and queued for CDB broadcast. A commit-stage flush overrides all of it.

## Interface
- WIDTH, 32: address/data width.
- LANES, 2: instructions presented per cycle (≥1).
- TAGW, 5: ROB tag width.
- QDEPTH, 4: U-type result queue depth (power of two, ≥ LANES).

- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- laneValid  in  LANES  lane holds a valid instruction.
- isBranch, isJAL, isLUI, isAUIPC  in  LANES each  decoded type; at most one set per lane.
- PC, immExt, predictedPC  in  LANES*WIDTH  per-lane fields; lane i occupies bits [i*WIDTH +: WIDTH].
- robTag  in  LANES*TAGW  per-lane ROB tag.
- commitFlush  in  1  commit-stage flush; highest priority.
- fetchReady  in  1  fetch accepts the redirect.
- cdbGrant  in  1  CDB arbiter grant for the current cdbReq.
- stall  out  1  rename must hold its lanes this cycle (combinational).
- redirectValid  out  1  registered redirect pending.
- redirectPC  out  WIDTH  correct target.
- redirectTag  out  TAGW  ROB tag of the misdirected instruction.
- laneKill  out  LANES  registered mask of lanes younger than the misdirected lane.
- cdbReq  out  1  queue non-empty.
- cdbData  out  WIDTH  head result.
- cdbTag  out  TAGW  head tag.

## Operation
- Per-lane target: PC+immExt, computed modulo 2^WIDTH (carry discarded).
- Lane misdirect: laneValid & (isBranch|isJAL) & target≠predictedPC.
- Selected lane m: lowest-index misdirected lane.
- Accept condition: lanes are accepted only when stall=0 and commitFlush=0.
- On accept with a misdirect:
  - Load redirectPC, redirectTag and laneKill. laneKill bit i=1 for every i>m; all other bits 0.
  - Set redirectValid.
- Redirect hold register: redirectValid stays 1 while fetchReady=0, and clears on the cycle fetchReady=1.
- U-type results:
  - LUI result = immExt; AUIPC result = PC+immExt.
  - On accept, every valid U-type lane with index < m (or every valid U-type lane if there is no misdirect) is enqueued in lane order.
- Queue: FIFO, QDEPTH entries, circular read/write pointers that wrap modulo QDEPTH. It dequeues on cdbReq & cdbGrant. Enqueue and dequeue in the same cycle are allowed.
- stall = redirectValid | (count > QDEPTH-LANES). Stall does not depend on how many U-type lanes are present.
- commitFlush=1:
  - Clears redirectValid, laneKill and the queue (count=0, pointers=0) at the next edge.
  - Captures nothing.
  - Any grant in that cycle has no effect.
- Reset: every output register and the count are 0. redirectPC, redirectTag, cdbData and cdbTag read 0 at reset.

## Timing
- Redirect latency: 1 cycle. Lanes are sampled at edge N; redirectValid=1 from edge N to the edge that samples fetchReady=1.
- The redirect is a level handshake: fetch sees a stable redirectPC until it accepts.
- U-type latency: a lane enqueued at edge N asserts cdbReq from N (when the queue was empty). cdbData/cdbTag are driven combinationally from the head entry.
- Stall is combinational from registered state only. It has no combinational path from lane inputs.
- Flush and accept in the same cycle: flush wins and lanes are dropped.
- Asserting resetn low mid-operation clears all state immediately.

## Configuration
- BRU_STATS_EN defined: adds a 16-bit saturating counter output misdirectCount and a 16-bit saturating counter output killedLaneCount.
  - misdirectCount increments on each captured redirect.
  - killedLaneCount increments by the popcount of the captured laneKill masked by laneValid.
  - Both counters reset to 0; they are not cleared by commitFlush.
- BRU_STATS_EN undefined: the counters and their ports are absent. Behaviour is otherwise identical.

## Test plan
- Correct prediction, LANES=2:
  - Stimulus: lane0 branch, PC=0x100, imm=0x20, pred=0x120.
  - Response: redirectValid stays 0, stall=0.
- Oldest misdirect wins, hold until fetch accepts:
  - Stimulus: lane0 JAL, PC=0x200, imm=0x40, pred=0x204, tag 3; lane1 branch also misdirected; fetchReady=0 for 2 cycles.
  - Response: next cycle redirectPC=0x240, redirectTag=3, laneKill=2'b10. Held 3 cycles, stall=1 throughout, then clears.
- Wrap-around arithmetic:
  - Stimulus: branch, PC=0xFFFF_FFF0, imm=0x20, pred=0.
  - Response: redirectPC=0x0000_0010.
- U-type queue:
  - Stimulus: lane0 AUIPC, PC=0x1000, imm=0x5000, tag 1; lane1 LUI, imm=0xABCD_E000, tag 2.
  - Response: cdbReq=1 next cycle; grants deliver (0x6000,1) then (0xABCD_E000,2).
  - Fill check: after fill to count=3 with QDEPTH=4, stall=1.
- Flush priority:
  - Stimulus: redirect pending, queue count=2, commitFlush=1 with a new misdirected lane and cdbGrant=1.
  - Response: next cycle redirectValid=0, cdbReq=0, laneKill=0, nothing captured.
- Async reset mid-redirect:
  - Stimulus: pull resetn low between edges while redirectValid=1.
  - Response: all outputs 0 immediately; with BRU_STATS_EN, counters read 0.
